// File: rtl/output_drain_ctrl.sv
// Output-stationary array drain: captures the bottom-row result bus, writes it to BRAM,
// then shifts the array south one row, repeating until every row has been written.
module output_drain_ctrl #(
    parameter int DW        = 16,
    parameter int Dimension = 16,
    parameter int ADDR_W    = 10,
    parameter int EJECT_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    output logic                        busy,
    output logic                        done,
    output logic [Dimension-1:0]        output_eject_ctrl,
    output logic [Dimension*Dimension-1:0] en_out,
    input  logic [DW*Dimension-1:0]     array_out,
    output logic                        bram_we,
    output logic [ADDR_W-1:0]           bram_addr,
    output logic [DW*Dimension-1:0]     bram_wdata,
    input  logic                        bram_ready
);

    localparam int ROW_W    = (Dimension > 1) ? $clog2(Dimension) : 1;
    localparam int WAIT_W   = $clog2(EJECT_LAT + 1);
    localparam int ROW_BITS = DW * Dimension;
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(Dimension - 1);
    localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(EJECT_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WRITE,
        S_SHIFT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ROW_W-1:0]    row_cnt_reg, row_cnt_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ROW_BITS-1:0] wdata_reg, wdata_next;
    logic                shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            row_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            row_cnt_reg  <= row_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        row_cnt_next  = row_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        busy          = 1'b0;
        done          = 1'b0;
        bram_we       = 1'b0;
        shift         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next    = base_addr;
                    row_cnt_next = '0;
                    state_next   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy       = 1'b1;
                wdata_next = array_out;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                busy    = 1'b1;
                bram_we = 1'b1;
                // Address and data registers only move on acceptance, so a stall holds them.
                if (bram_ready) begin
                    if (row_cnt_reg == LAST_ROW) begin
                        state_next = S_DONE;
                    end else begin
                        row_cnt_next = row_cnt_reg + 1'b1;
                        addr_next    = addr_reg + 1'b1;
                        state_next   = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                busy          = 1'b1;
                shift         = 1'b1;
                wait_cnt_next = LAT_LOAD;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wait_cnt_reg != '0) begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
                if (wait_cnt_reg <= WAIT_W'(1)) begin
                    state_next = S_CAPTURE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign output_eject_ctrl = {Dimension{shift}};
    assign en_out            = {(Dimension * Dimension){shift}};
    assign bram_addr         = addr_reg;
    assign bram_wdata        = wdata_reg;

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Directed bench for output_drain_ctrl: two instances (eject latency 1 and 3) each fed by
// a 4x4 array model that shifts south when ejected; passes described by a vector table.
module tb_output_drain_ctrl;

    localparam int DW = 16;
    localparam int D  = 4;
    localparam int AW = 10;
    localparam int RW = DW * D;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic bram_ready = 1'b1;

    logic            start_s [2];
    logic            busy_s  [2];
    logic            done_s  [2];
    logic [D-1:0]    ej_s    [2];
    logic [D*D-1:0]  en_s    [2];
    logic [RW-1:0]   aout_s  [2];
    logic            we_s    [2];
    logic [AW-1:0]   addr_s  [2];
    logic [RW-1:0]   wd_s    [2];

    logic [DW-1:0] arr [2][D][D];
    int            pend [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    output_drain_ctrl #(.DW(DW), .Dimension(D), .ADDR_W(AW), .EJECT_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .base_addr(base_addr),
        .busy(busy_s[0]), .done(done_s[0]), .output_eject_ctrl(ej_s[0]), .en_out(en_s[0]),
        .array_out(aout_s[0]), .bram_we(we_s[0]), .bram_addr(addr_s[0]),
        .bram_wdata(wd_s[0]), .bram_ready(bram_ready)
    );

    output_drain_ctrl #(.DW(DW), .Dimension(D), .ADDR_W(AW), .EJECT_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start_s[1]), .base_addr(base_addr),
        .busy(busy_s[1]), .done(done_s[1]), .output_eject_ctrl(ej_s[1]), .en_out(en_s[1]),
        .array_out(aout_s[1]), .bram_we(we_s[1]), .bram_addr(addr_s[1]),
        .bram_wdata(wd_s[1]), .bram_ready(bram_ready)
    );

    // Array model: a shift request seen at a clock edge becomes visible LAT cycles later.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit sh;
            int lat;
            sh  = 1'b0;
            lat = (i == 0) ? 1 : 3;
            if (load) begin
                pend[i] <= 0;
                for (int r = 0; r < D; r++)
                    for (int c = 0; c < D; c++)
                        arr[i][r][c] <= DW'(r * 16 + c);
            end else begin
                if (&ej_s[i]) begin
                    if (lat == 1) sh = 1'b1;
                    else pend[i] <= lat - 1;
                end else if (pend[i] > 0) begin
                    pend[i] <= pend[i] - 1;
                    if (pend[i] == 1) sh = 1'b1;
                end
                if (sh) begin
                    for (int r = 0; r < D; r++)
                        for (int c = 0; c < D; c++)
                            arr[i][r][c] <= (r == 0) ? '0 : arr[i][r-1][c];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            aout_s[i] = '0;
            for (int c = 0; c < D; c++)
                aout_s[i][c*DW +: DW] = arr[i][D-1][c];
        end
    end

    typedef struct {
        int                   inst;
        logic [AW-1:0]        base;
        int                   stall_k;
        int                   stall_len;
        int                   mid_start;
        logic [D-1:0][AW-1:0] exp_addr;
        int                   exp_done;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_row(input int k);
        logic [RW-1:0] r;
        r = '0;
        for (int c = 0; c < D; c++)
            r[c*DW +: DW] = DW'((D - 1 - k) * 16 + c);
        return r;
    endfunction

    task automatic check_idle_zero(input int i, input string tag);
        check({tag, "_busy"}, 64'(busy_s[i]), 64'd0);
        check({tag, "_done"}, 64'(done_s[i]), 64'd0);
        check({tag, "_we"},   64'(we_s[i]),   64'd0);
        check({tag, "_ej"},   64'(ej_s[i]),   64'd0);
        check({tag, "_en"},   64'(en_s[i]),   64'd0);
        check({tag, "_addr"}, 64'(addr_s[i]), 64'd0);
        check({tag, "_wd"},   64'(wd_s[i]),   64'd0);
    endtask

    task automatic run_pass(input int id, input vec_t v);
        int i;
        int writes;
        int shifts;
        int dones;
        int done_t;
        int stall_left;
        bit stalling;
        logic [AW-1:0] held_a;
        logic [RW-1:0] held_d;
        i = v.inst; writes = 0; shifts = 0; dones = 0; done_t = -1;
        stall_left = v.stall_len; stalling = 1'b0; held_a = '0; held_d = '0;

        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
        base_addr = v.base; bram_ready = 1'b1; start_s[i] = 1'b1;
        @(negedge clk); start_s[i] = 1'b0;
        check("busy_after_start", 64'(busy_s[i]), 64'd1);
        for (int t = 1; t <= v.exp_done + 3; t++) begin
            if (v.mid_start != 0 && t == 6) begin
                start_s[i] = 1'b1; base_addr = 10'h100;
            end else if (v.mid_start != 0 && t == 7) begin
                start_s[i] = 1'b0;
            end
            if (we_s[i] && writes == v.stall_k && stall_left > 0) begin
                bram_ready = 1'b0;
                stall_left--;
                if (!stalling) begin
                    held_a = addr_s[i]; held_d = wd_s[i]; stalling = 1'b1;
                end else begin
                    check("stall_addr_hold", 64'(addr_s[i]), 64'(held_a));
                    check("stall_data_hold", 64'(wd_s[i]), 64'(held_d));
                    check("stall_no_eject", 64'(ej_s[i]), 64'd0);
                end
            end else begin
                bram_ready = 1'b1;
            end
            if (we_s[i] && bram_ready) begin
                $display("pass %0d write %0d addr=%03h data=%016h", id, writes, addr_s[i], wd_s[i]);
                if (writes < D) begin
                    check("write_addr", 64'(addr_s[i]), 64'(v.exp_addr[writes]));
                    check("write_data", 64'(wd_s[i]), 64'(exp_row(writes)));
                end
                writes++;
            end
            if (ej_s[i] != '0) begin
                shifts++;
                check("eject_all_ones", 64'(ej_s[i]), 64'({D{1'b1}}));
                check("en_out_all_ones", 64'(en_s[i]), 64'({(D*D){1'b1}}));
            end
            if (done_s[i]) begin
                dones++;
                if (done_t < 0) done_t = t;
                check("busy_low_at_done", 64'(busy_s[i]), 64'd0);
            end
            @(negedge clk);
        end
        bram_ready = 1'b1;
        check("write_count", 64'(writes), 64'(D));
        check("shift_count", 64'(shifts), 64'(D - 1));
        check("done_count", 64'(dones), 64'd1);
        check("done_cycle", 64'(done_t), 64'(v.exp_done));
        check("busy_idle_end", 64'(busy_s[i]), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int shifts;
        bit found;
        bit saw_done;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;

        // inst, base, stall write, stall cycles, mid-pass start, addresses (write3..write0), done cycle
        vecs[0] = '{inst:0, base:10'h010, stall_k:-1, stall_len:0, mid_start:0,
                    exp_addr:{10'h013, 10'h012, 10'h011, 10'h010}, exp_done:15};
        vecs[1] = '{inst:0, base:10'h010, stall_k:1, stall_len:5, mid_start:0,
                    exp_addr:{10'h013, 10'h012, 10'h011, 10'h010}, exp_done:20};
        vecs[2] = '{inst:0, base:10'h3FE, stall_k:-1, stall_len:0, mid_start:0,
                    exp_addr:{10'h001, 10'h000, 10'h3FF, 10'h3FE}, exp_done:15};
        vecs[3] = '{inst:0, base:10'h080, stall_k:-1, stall_len:0, mid_start:1,
                    exp_addr:{10'h083, 10'h082, 10'h081, 10'h080}, exp_done:15};
        vecs[4] = '{inst:1, base:10'h010, stall_k:-1, stall_len:0, mid_start:0,
                    exp_addr:{10'h013, 10'h012, 10'h011, 10'h010}, exp_done:21};
        vecs[5] = '{inst:1, base:10'h200, stall_k:3, stall_len:2, mid_start:0,
                    exp_addr:{10'h203, 10'h202, 10'h201, 10'h200}, exp_done:23};
        vecs[6] = '{inst:0, base:10'h040, stall_k:-1, stall_len:0, mid_start:0,
                    exp_addr:{10'h043, 10'h042, 10'h041, 10'h040}, exp_done:15};

        #3;
        check_idle_zero(0, "reset_lat1");
        check_idle_zero(1, "reset_lat3");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 6; n++) run_pass(n, vecs[n]);

        // Reset during the WAIT that follows the second shift, then a clean pass.
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
        base_addr = 10'h020; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        shifts = 0; found = 1'b0; saw_done = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            if (done_s[0]) saw_done = 1'b1;
            if (&ej_s[0]) shifts++;
            @(negedge clk);
            if (shifts == 2) found = 1'b1;
        end
        check("reset_reached_wait", 64'(found), 64'd1);
        check("reset_no_early_done", 64'(saw_done), 64'd0);
        #2 rst = 1'b0;
        #1 check_idle_zero(0, "midreset");
        @(negedge clk);
        check("midreset_no_done", 64'(done_s[0]), 64'd0);
        check("midreset_idle_busy", 64'(busy_s[0]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("after_reset_idle", 64'(busy_s[0]), 64'd0);
        run_pass(6, vecs[6]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
